// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl
// Time-shared scanner for a 4x4 active-low matrix keypad. One row is driven
// low at a time. The columns are sampled at the end of each row dwell into a
// full-matrix snapshot. Snapshots are debounced over consecutive scans, and
// newly pressed keys are queued and emitted one at a time on a valid/ready
// port.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   row_n[3:0]   row drive, active-low, exactly one bit low
//   col_n[3:0]   column sense, active-low, already synchronised
//   key_valid    event available
//   key_code[3:0] event key index = row*4 + col
//   key_ready    consumer accepts the event when key_valid & key_ready
//   key_state[15:0] committed debounced pressed map, bit row*4+col
//   overrun      sticky flag: a press was merged/lost
//   overrun_clr  clears overrun (a coincident new overrun wins)
// ---------------------------------------------------------------------------
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 3000,
  parameter int unsigned DEBOUNCE_SCANS = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ready,
  output logic [15:0] key_state,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned RUN_W = 4;
  localparam int unsigned KEY_N = 16;

  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(DEBOUNCE_SCANS);

  // Sequencer and debounce state
  logic [DIV_W-1:0] dwell;
  logic [1:0]       row_idx;
  logic [KEY_N-1:0] snap;
  logic             scan_done;
  logic [KEY_N-1:0] prev_snap;
  logic [RUN_W-1:0] run_cnt;
  logic [KEY_N-1:0] pending;

  // Combinational debounce / scheduler terms
  logic             snap_match_c;
  logic [RUN_W-1:0] run_next_c;
  logic             commit_c;
  logic [KEY_N-1:0] new_press_c;
  logic [KEY_N-1:0] held_mask_c;
  logic [KEY_N-1:0] merged_c;
  logic [KEY_N-1:0] queue_c;
  logic             load_c;
  logic [3:0]       pick_idx_c;
  logic [KEY_N-1:0] pick_mask_c;
  logic [KEY_N-1:0] pending_next_c;
  logic             key_valid_next_c;
  logic [3:0]       key_code_next_c;

  // Lowest-index set bit; returns 0 for an empty vector.
  function automatic logic [3:0] lowest_idx(input logic [KEY_N-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = KEY_N - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Row sequencer: dwell counter, row rotation, column sampling, scan_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell     <= '0;
      row_idx   <= 2'd0;
      row_n     <= 4'b1110;
      snap      <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= (dwell == DWELL_LAST) && (row_idx == 2'd3);
      if (dwell == DWELL_LAST) begin
        dwell                      <= '0;
        row_idx                    <= row_idx + 2'd1;
        row_n                      <= {row_n[2:0], row_n[3]};
        // Sample at the end of the dwell so the columns have settled.
        snap[{row_idx, 2'b00} +: 4] <= ~col_n;
      end else begin
        dwell <= dwell + DIV_W'(1);
      end
    end
  end

  // Debounce evaluation, new-press detection and output scheduling.
  always_comb begin
    snap_match_c = (snap == prev_snap);
    if (!snap_match_c) begin
      run_next_c = RUN_W'(1);
    end else if (run_cnt >= RUN_MAX) begin
      run_next_c = RUN_MAX;
    end else begin
      run_next_c = run_cnt + RUN_W'(1);
    end

    commit_c    = scan_done && (run_next_c == RUN_MAX) && (snap != key_state);
    new_press_c = commit_c ? (snap & ~key_state) : '0;

    // A press of the code already waiting in the output register, or of a
    // code already queued, collapses into the existing event.
    held_mask_c = key_valid ? (KEY_N'(1) << key_code) : '0;
    merged_c    = new_press_c & (pending | held_mask_c);
    queue_c     = pending | (new_press_c & ~held_mask_c);

    load_c      = ~key_valid | key_ready;
    pick_idx_c  = lowest_idx(queue_c);
    pick_mask_c = KEY_N'(1) << pick_idx_c;

    pending_next_c   = queue_c;
    key_valid_next_c = key_valid;
    key_code_next_c  = key_code;
    if (load_c) begin
      if (queue_c != '0) begin
        pending_next_c   = queue_c & ~pick_mask_c;
        key_valid_next_c = 1'b1;
        key_code_next_c  = pick_idx_c;
      end else begin
        key_valid_next_c = 1'b0;
      end
    end
  end

  // Debounce and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_snap <= '0;
      run_cnt   <= RUN_MAX;
      key_state <= '0;
      pending   <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      overrun   <= 1'b0;
    end else begin
      if (scan_done) begin
        prev_snap <= snap;
        run_cnt   <= run_next_c;
      end
      if (commit_c) begin
        key_state <= snap;
      end
      pending   <= pending_next_c;
      key_valid <= key_valid_next_c;
      key_code  <= key_code_next_c;
      if (merged_c != '0) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_ctrl
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_SCANS=3
// (one full scan = 16 cycles). A behavioural keypad drives col_n from the
// set of pressed keys and the current row drive.
// ---------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [15:0] key_state;
  logic        overrun;
  logic        overrun_clr;

  logic [15:0] pressed;
  int          cyc;
  int          checks;
  int          failures;
  logic [3:0]  ev_q[$];

  keypad_scan_ctrl #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .key_state  (key_state),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  // Cycle number: 0 is the first cycle with rst low.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Record every accepted event.
  always @(posedge clk) begin
    if (!rst && key_valid && key_ready) ev_q.push_back(key_code);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge inside cycle n (bounded).
  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      failures++;
      $display("FAIL goto observed=%0d expected=%0d", cyc, n);
    end
  endtask

  // Hold reset for two edges; returns at the negedge of cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ev_q.delete();
  endtask

  function automatic logic [3:0] ev_at(input int i);
    if (i < ev_q.size()) return ev_q[i];
    return 4'hx;
  endfunction

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    key_ready   = 1'b1;
    overrun_clr = 1'b0;
    pressed     = 16'h0000;

    // ---- Key 6 held from reset ----
    pressed = 16'h0040;
    do_reset();
    chk("rst_row_n", 32'(row_n), 32'h0000000E);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_state", 32'(key_state), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    goto(48);
    chk("k6_valid_48", 32'(key_valid), 32'h0);
    chk("k6_state_48", 32'(key_state), 32'h0);
    goto(49);
    chk("k6_valid_49", 32'(key_valid), 32'h1);
    chk("k6_code_49", 32'(key_code), 32'h6);
    chk("k6_state_49", 32'(key_state), 32'h0040);
    goto(50);
    chk("k6_valid_50", 32'(key_valid), 32'h0);
    chk("k6_events", 32'(ev_q.size()), 32'd1);

    // ---- Keys 3 and 12 in the same scan ----
    pressed = 16'h1008;
    do_reset();
    goto(49);
    chk("k3_valid", 32'(key_valid), 32'h1);
    chk("k3_code", 32'(key_code), 32'h3);
    chk("k3_state", 32'(key_state), 32'h1008);
    goto(50);
    chk("k12_valid", 32'(key_valid), 32'h1);
    chk("k12_code", 32'(key_code), 32'hC);
    goto(51);
    chk("k12_done", 32'(key_valid), 32'h0);
    goto(60);
    pressed = 16'h0000;
    goto(200);
    chk("rel_state", 32'(key_state), 32'h0);
    chk("rel_events", 32'(ev_q.size()), 32'd2);
    chk("rel_ev0", 32'(ev_at(0)), 32'h3);
    chk("rel_ev1", 32'(ev_at(1)), 32'hC);

    // ---- Key 0 toggled every scan: never three matching snapshots ----
    pressed = 16'h0001;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      goto(k * 16);
      pressed[0] = ~pressed[0];
    end
    goto(220);
    chk("bounce_state", 32'(key_state), 32'h0);
    chk("bounce_events", 32'(ev_q.size()), 32'd0);
    chk("bounce_valid", 32'(key_valid), 32'h0);

    // ---- Key 5 re-pressed while its event is stalled ----
    key_ready = 1'b0;
    pressed   = 16'h0020;
    do_reset();
    goto(49);
    chk("k5_valid_49", 32'(key_valid), 32'h1);
    chk("k5_code_49", 32'(key_code), 32'h5);
    goto(50);
    pressed = 16'h0000;
    goto(100);
    chk("k5_rel_state", 32'(key_state), 32'h0);
    chk("k5_hold_valid", 32'(key_valid), 32'h1);
    chk("k5_hold_code", 32'(key_code), 32'h5);
    chk("k5_no_ovr", 32'(overrun), 32'h0);
    pressed = 16'h0020;
    goto(145);
    chk("k5_ovr", 32'(overrun), 32'h1);
    chk("k5_state2", 32'(key_state), 32'h0020);
    chk("k5_hold_code2", 32'(key_code), 32'h5);
    goto(150);
    key_ready = 1'b1;
    goto(151);
    chk("k5_drained", 32'(key_valid), 32'h0);
    goto(158);
    chk("k5_events", 32'(ev_q.size()), 32'd1);
    chk("k5_ev0", 32'(ev_at(0)), 32'h5);
    chk("k5_ovr_sticky", 32'(overrun), 32'h1);
    goto(160);
    overrun_clr = 1'b1;
    goto(161);
    overrun_clr = 1'b0;
    chk("k5_ovr_clr", 32'(overrun), 32'h0);

    // ---- Reset pulse with an event held and one queued ----
    key_ready = 1'b0;
    pressed   = 16'h1008;
    do_reset();
    goto(49);
    chk("rp_valid", 32'(key_valid), 32'h1);
    chk("rp_code", 32'(key_code), 32'h3);
    goto(52);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pressed   = 16'h0000;
    key_ready = 1'b1;
    ev_q.delete();
    chk("rp_cyc", 32'(cyc), 32'd0);
    chk("rp_valid0", 32'(key_valid), 32'h0);
    chk("rp_overrun", 32'(overrun), 32'h0);
    chk("rp_state", 32'(key_state), 32'h0);
    chk("rp_row_n", 32'(row_n), 32'h0000000E);
    goto(100);
    chk("rp_no_stale", 32'(ev_q.size()), 32'd0);
    chk("rp_valid_end", 32'(key_valid), 32'h0);

    // ---- Row drive sequence over 64 cycles ----
    do_reset();
    for (int n = 0; n < 64; n++) begin
      logic [3:0] exp_row;
      goto(n);
      exp_row = ~(4'b0001 << ((n / 4) % 4));
      chk("row_seq", 32'(row_n), 32'(exp_row));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for a 4x4 active-low matrix keypad. It sequences the row drives and samples the columns once per row dwell. It debounces whole-matrix snapshots over consecutive scans and queues newly pressed keys. Keys are emitted one at a time on a valid/ready event port, so the per-key debounce/pulse datapath is replaced by a single time-shared scanner that feeds the board's key-event consumers.

## Interface
- SCAN_DIV, 3000: clock cycles each row is driven; minimum 2.
- DEBOUNCE_SCANS, 8: consecutive identical full-matrix snapshots required to commit a new stable map; range 1..15.
- clk  input  1  system clock.
- rst  input  1  reset. **Synchronous and active-high.**
- row_n  output  4  row drive, active-low, exactly one bit low.
- col_n  input  4  column sense, active-low, externally pulled up, already synchronised.
- key_valid  output  1  event available.
- key_code  output  4  event key index = row*4 + col.
- key_ready  input  1  consumer accepts the event when key_valid & key_ready.
- key_state  output  16  committed debounced pressed map; bit row*4+col.
- overrun  output  1  sticky flag: a press was lost.
- overrun_clr  input  1  clears overrun.

## Operation
- Reset values:
  - row_n = 4'b1110 (row 0), dwell counter 0.
  - key_valid 0, key_code 0, key_state 0, overrun 0.
  - pending 0, prev_snap 0, run_cnt = DEBOUNCE_SCANS.
- Row sequencer:
  - Dwell counter runs 0..SCAN_DIV-1 per row, and rows advance 0,1,2,3,0… (wrap-around).
  - Columns are sampled only at dwell count SCAN_DIV-1, after settling.
  - Sampled bit for (r,c) = ~col_n[c], written to snap[r*4+c].
  - The edge ending row 3's last dwell cycle raises scan_done for one cycle.
- Debounce, evaluated in the scan_done cycle:
  - If snap == prev_snap, run_cnt saturates up at DEBOUNCE_SCANS. Otherwise run_cnt = 1.
  - prev_snap <= snap.
  - Commit when the updated run_cnt == DEBOUNCE_SCANS and snap != key_state.
  - On commit: key_state <= snap, and new_press = snap & ~key_state.
  - Releases only clear key_state bits and never generate events.
- Pending queue (scheduler):
  - pending |= new_press.
  - If a new_press bit is already set in pending, or is the code currently held in the output register with key_valid high, that press is merged and overrun <= 1.
- Output register:
  - Loads when key_valid == 0 or a handshake happens this cycle.
  - It takes the lowest-index set bit of (pending | new_press), clears that bit, and sets key_valid.
  - If nothing is queued, key_valid <= 0.
  - Back-to-back events are allowed.
- key_code and key_valid are stable while key_valid & ~key_ready.
- overrun_clr clears overrun. If it coincides with a new overrun, set wins.
- rst asserted mid-scan or mid-handshake returns everything to the reset values on the next edge, and queued events are discarded.

## Timing
- Full scan = 4*SCAN_DIV cycles. Cycle 0 is the first cycle with rst low.
- Row r is driven in cycles [r*SCAN_DIV, (r+1)*SCAN_DIV-1] modulo 4*SCAN_DIV.
- scan_done is high in cycles k*4*SCAN_DIV, for k ≥ 1.
- Press-to-event latency:
  - Commit at the scan_done cycle of the DEBOUNCE_SCANS-th matching scan.
  - key_valid rises the next cycle, because the output load uses new_press directly.
- A key held from reset gives key_valid first high in cycle DEBOUNCE_SCANS*4*SCAN_DIV + 1.
- After a handshake in cycle t, the next queued event is valid in cycle t+1.
- Minimum detectable press is DEBOUNCE_SCANS scans. Bounces shorter than one scan either reset run_cnt or are never sampled.

## Test plan
Run with SCAN_DIV=4 and DEBOUNCE_SCANS=3; a full scan is 16 cycles.
- Key 6 (row1, col2) held from reset, key_ready=1 -> key_valid high exactly in cycle 49 with key_code=6 for one cycle, and key_state=16'h0040 from cycle 49.
- Keys 3 and 12 pressed in the same scan, key_ready=1 -> events 3 then 12 on consecutive cycles. Releasing both later gives no events and key_state returns to 0.
- Key 0 toggled every 16 cycles, so no three matching scans -> no key_valid, and key_state stays 0.
- key_ready=0 while key 5 commits, then key 5 is released and re-pressed and commits again -> key_code=5 held stable, overrun=1. With ready=1, exactly one event 5 is delivered and overrun stays 1 until overrun_clr.
- rst pulsed for one cycle while key_valid=1 and pending is non-empty -> next cycle key_valid=0, overrun=0, key_state=0, row_n=4'b1110, and no stale event afterwards.
- row_n check over 64 cycles: exactly one low bit, sequence 1110, 1101, 1011, 0111, each held for 4 cycles, wrapping.
